sevenseg_scan_reader: RTL

Receive-side counterpart of the team's seven-segment display path. It samples a multiplexed seven-segment bus: per-segment lines plus one-hot digit enables, as driven by a scanning display controller. It recovers the hexadecimal value shown at each digit position and signals when a complete display frame has been captured. It is used for loop-back checking of the display drivers and for reading segment outputs from external boards.

---
 rtl/sevenseg_pkg.sv | 41 ++++
 rtl/sevenseg_pattern_decode.sv | 24 ++
 rtl/sevenseg_scan_reader.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and the seven-segment pattern table for the scan reader.
// Patterns are written {g..a}, active-high.
package sevenseg_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned HEX_W  = 4;
  localparam int unsigned NUM_HEX = 16;

  typedef logic [HEX_W-1:0] hex_t;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    COUNT = 2'd1,
    HELD  = 2'd2
  } state_t;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Index into the table is the hex value shown by that pattern.
  localparam logic [SEG_W-1:0] SEG_TABLE [NUM_HEX] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Combinational seven-segment pattern to hex decoder.
// Blank (all segments off) is reported separately and is not a legal digit.
module sevenseg_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [SEG_W-1:0] i_pattern,
  output hex_t             o_value_c,
  output logic             o_legal_c,
  output logic             o_blank_c
);

  always_comb begin
    o_value_c = '0;
    o_legal_c = 1'b0;
    o_blank_c = (i_pattern == SEG_BLANK);
    for (int i = 0; i < int'(NUM_HEX); i++) begin
      if (i_pattern == SEG_TABLE[i]) begin
        o_value_c = HEX_W'(i);
        o_legal_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sevenseg_scan_reader.sv
// Samples a scanned seven-segment bus, commits each digit once it has dwelt
// for STABLE_CYCLES identical samples, and flags complete frames.
module sevenseg_scan_reader
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SEG_W-1:0]            seg,
  input  logic [NUM_DIGITS-1:0]       an,
  output logic [HEX_W*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]       digit_valid,
  output logic                        frame_done,
  output logic                        pattern_err
);

  localparam int unsigned SMP_W = NUM_DIGITS + SEG_W;
  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned DIG_W = HEX_W * NUM_DIGITS;

  logic [SMP_W-1:0]      r_sync1;
  logic [SMP_W-1:0]      r_sync2;
  logic [SMP_W-1:0]      r_prev;
  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_DIGITS-1:0] r_seen;
  logic [DIG_W-1:0]      r_digits;
  logic [NUM_DIGITS-1:0] r_valid;
  logic                  r_frame_done;
  logic                  r_pattern_err;

  logic [NUM_DIGITS-1:0] w_an;
  logic [SEG_W-1:0]      w_seg;
  logic                  w_onehot;
  logic                  w_same;
  logic                  w_commit;
  hex_t                  w_value;
  logic                  w_legal;
  logic                  w_blank;
  logic [NUM_DIGITS-1:0] w_seen_next;

  // Two-flop synchronizer on the whole {an, seg} bundle; r_prev is the prior sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= {an, seg};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_an        = r_sync2[SMP_W-1:SEG_W];
  assign w_seg       = r_sync2[SEG_W-1:0];
  assign w_onehot    = (w_an != '0) && ((w_an & (w_an - NUM_DIGITS'(1))) == '0);
  assign w_same      = (r_sync2 == r_prev);
  assign w_commit    = (r_state == COUNT) && w_same &&
                       (r_cnt == CNT_W'(STABLE_CYCLES - 1));
  assign w_seen_next = r_seen | w_an;

  sevenseg_pattern_decode u_decode (
    .i_pattern (w_seg),
    .o_value_c (w_value),
    .o_legal_c (w_legal),
    .o_blank_c (w_blank)
  );

  // Dwell tracker: one commit per run of STABLE_CYCLES identical one-hot samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        WAIT: begin
          if (w_onehot) begin
            r_state <= COUNT;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt   <= '0;
          end
        end
        COUNT: begin
          if (!w_same) begin
            r_state <= w_onehot ? COUNT : WAIT;
            r_cnt   <= w_onehot ? CNT_W'(1) : '0;
          end else if (w_commit) begin
            r_state <= HELD;
            r_cnt   <= CNT_W'(STABLE_CYCLES);
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!w_same) begin
            r_state <= w_onehot ? COUNT : WAIT;
            r_cnt   <= w_onehot ? CNT_W'(1) : '0;
          end
        end
        default: begin
          r_state <= WAIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Per-position results, frame tracking and the two event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits      <= '0;
      r_valid       <= '0;
      r_seen        <= '0;
      r_frame_done  <= 1'b0;
      r_pattern_err <= 1'b0;
    end else begin
      r_frame_done  <= 1'b0;
      r_pattern_err <= 1'b0;
      if (w_commit) begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
          if (w_an[i]) begin
            if (w_legal) begin
              r_digits[HEX_W*i +: HEX_W] <= w_value;
              r_valid[i]                 <= 1'b1;
            end else if (w_blank) begin
              r_digits[HEX_W*i +: HEX_W] <= '0;
              r_valid[i]                 <= 1'b0;
            end else begin
              r_valid[i]                 <= 1'b0;
            end
          end
        end
        r_pattern_err <= !w_legal && !w_blank;
        if (&w_seen_next) begin
          r_seen       <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_seen       <= w_seen_next;
        end
      end
    end
  end

  assign digits      = r_digits;
  assign digit_valid = r_valid;
  assign frame_done  = r_frame_done;
  assign pattern_err = r_pattern_err;

endmodule
